// File: rtl/offset_uart_pkg.sv
// ---------------------------------------------------------------------------
// offset_uart_pkg
// Shared types and constants for the offset UART transmitter:
//   state_t   - transmitter FSM states
//   SYNC_BYTE - first byte of every record, lets the receiver find alignment
//   baud_div  - rounded integer clock divider for a given clock and bit rate
// ---------------------------------------------------------------------------
package offset_uart_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START_BIT = 2'd1,
    DATA_BITS = 2'd2,
    STOP_BIT  = 2'd3
  } state_t;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  // Nearest-integer divider; at 50 MHz / 115200 this gives 434.
  function automatic int baud_div(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/offset_uart_tx_sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with show-ahead read data.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset (empties the FIFO)
//   push, din   - write request and data; accepted when not full, or when
//                 full and a pop happens in the same cycle
//   pop, dout   - read request; dout always shows the oldest entry
//   full, empty - registered status flags, updated on the push/pop edge
// Pointers carry one extra wrap bit so full and empty are distinguishable.
// ---------------------------------------------------------------------------
module sync_fifo #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [AW:0]      wr_nxt;
  logic [AW:0]      rd_nxt;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot the push lands in.
  assign do_push = push & (~full | do_pop);

  assign wr_nxt = wr_ptr + (AW+1)'(do_push);
  assign rd_nxt = rd_ptr + (AW+1)'(do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      wr_ptr <= wr_nxt;
      rd_ptr <= rd_nxt;
      full   <= (wr_nxt[AW] != rd_nxt[AW]) && (wr_nxt[AW-1:0] == rd_nxt[AW-1:0]);
      empty  <= (wr_nxt == rd_nxt);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

  assign dout = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/offset_uart_tx.sv
// ---------------------------------------------------------------------------
// offset_uart_tx
// Buffers correlator offset results and sends each as a two-byte 8N1 UART
// record: 0xA5 sync, then the offset sign-extended to 8 bits. Bit timing
// comes from an integer divider on CLOCK_50.
// Ports:
//   CLOCK_50     - system clock, rising edge
//   RESET_N      - asynchronous active-low reset; forces the line idle at once
//   offset_in    - signed offset, sampled while offset_valid=1
//   offset_valid - push strobe, level sensitive (one record per cycle high)
//   UART_TX      - serial line, idle high
//   busy         - record on the line or records waiting in the FIFO
//   fifo_full    - FIFO holds FIFO_DEPTH records
//   drop_count   - results lost to a full FIFO, saturating at 255
// ---------------------------------------------------------------------------
module offset_uart_tx
  import offset_uart_pkg::*;
#(
  parameter int DATA_MSB   = 4,
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 115_200,
  parameter int FIFO_DEPTH = 8,
  parameter int FIFO_AW    = 3
) (
  input  logic                 CLOCK_50,
  input  logic                 RESET_N,
  input  logic signed [DATA_MSB:0] offset_in,
  input  logic                 offset_valid,
  output logic                 UART_TX,
  output logic                 busy,
  output logic                 fifo_full,
  output logic [7:0]           drop_count
);

  localparam int DIV   = baud_div(CLK_HZ, BAUD);
  localparam int CNT_W = $clog2(DIV + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  state_t                   state;
  logic [CNT_W-1:0]         baud_cnt;
  logic [2:0]               bit_idx;
  logic                     byte_idx;
  logic signed [DATA_MSB:0] payload;
  logic [7:0]               shift;
  logic [DATA_MSB:0]        fifo_dout;
  logic                     fifo_empty;
  logic                     pop;
  logic                     drop;
  logic                     bit_end;
  logic                     line_bit;

  function automatic logic [7:0] sign_ext(input logic signed [DATA_MSB:0] v);
    logic signed [7:0] w;
    w = 8'(v);
    return w;
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] c);
    return (c == 8'hFF) ? c : c + 8'd1;
  endfunction

  sync_fifo #(
    .WIDTH (DATA_MSB + 1),
    .DEPTH (FIFO_DEPTH),
    .AW    (FIFO_AW)
  ) u_fifo (
    .clk   (CLOCK_50),
    .rst_n (RESET_N),
    .push  (offset_valid),
    .pop   (pop),
    .din   (offset_in),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign pop     = (state == IDLE) & ~fifo_empty;
  assign drop    = offset_valid & fifo_full & ~pop;
  assign bit_end = (baud_cnt == LAST);
  assign busy    = (state != IDLE) | ~fifo_empty;

  always_comb begin
    line_bit = 1'b1;
    case (state)
      START_BIT: line_bit = 1'b0;
      DATA_BITS: line_bit = shift[0];
      default:   line_bit = 1'b1;
    endcase
  end

  // Control: FSM, baud/bit/byte counters, registered line output, drop counter.
  // UART_TX is registered from the current state, so the line trails the FSM
  // by one cycle: the pop edge enters START_BIT and the line falls one edge later.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state      <= IDLE;
      baud_cnt   <= '0;
      bit_idx    <= '0;
      byte_idx   <= 1'b0;
      UART_TX    <= 1'b1;
      drop_count <= '0;
    end else begin
      UART_TX <= line_bit;
      if (drop) drop_count <= sat_inc(drop_count);
      case (state)
        IDLE: begin
          if (pop) begin
            state    <= START_BIT;
            byte_idx <= 1'b0;
            baud_cnt <= '0;
          end
        end
        START_BIT: begin
          if (bit_end) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            state    <= DATA_BITS;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA_BITS: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) state <= STOP_BIT;
            else                 bit_idx <= bit_idx + 1'b1;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        STOP_BIT: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (!byte_idx) begin
              byte_idx <= 1'b1;
              state    <= START_BIT;
            end else begin
              state <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Data: payload capture and byte shifter; not reset, only read outside IDLE.
  always_ff @(posedge CLOCK_50) begin
    if (pop) begin
      payload <= fifo_dout;
      shift   <= SYNC_BYTE;
    end else if (state == DATA_BITS && bit_end) begin
      shift <= {1'b0, shift[7:1]};
    end else if (state == STOP_BIT && bit_end && !byte_idx) begin
      shift <= sign_ext(payload);
    end
  end

endmodule

// File: tb/tb_offset_uart_tx.sv
`timescale 1ns/1ps
module tb_offset_uart_tx;

  localparam int DIV = 434;
  localparam int REC = 20 * DIV;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] offset_in;
  logic       offset_valid;
  logic       uart_tx;
  logic       busy;
  logic       fifo_full;
  logic [7:0] drop_count;

  int          n_tests;
  int          n_fail;
  int          frame_err;
  bit          mon_en;
  logic [7:0]  byte_q[$];
  logic [15:0] exp_q[$];

  typedef struct {
    logic [4:0] off;
    logic [7:0] pay;
  } vec_t;
  vec_t tbl[3];

  always #10 clk = ~clk;

  offset_uart_tx dut (
    .CLOCK_50     (clk),
    .RESET_N      (rst_n),
    .offset_in    (offset_in),
    .offset_valid (offset_valid),
    .UART_TX      (uart_tx),
    .busy         (busy),
    .fifo_full    (fifo_full),
    .drop_count   (drop_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Call away from a clock edge; returns #1 after the push edge.
  task automatic pulse(input logic [4:0] v);
    offset_in    = v;
    offset_valid = 1'b1;
    @(posedge clk);
    #1 offset_valid = 1'b0;
  endtask

  task automatic expect_rec(input logic [7:0] pay);
    exp_q.push_back({8'hA5, pay});
  endtask

  task automatic drain(input int budget);
    int n;
    logic [15:0] e;
    logic [15:0] a;
    n = 0;
    while (byte_q.size() < 2 * exp_q.size() && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (byte_q.size() < 2 * exp_q.size()) begin
      n_tests++;
      n_fail++;
      $display("FAIL record timeout: got %0d bytes, expected %0d", byte_q.size(), 2 * exp_q.size());
      exp_q.delete();
      byte_q.delete();
    end else begin
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a[15:8] = byte_q.pop_front();
        a[7:0]  = byte_q.pop_front();
        check("record", a, e);
      end
    end
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (busy !== 1'b0) begin
      n_tests++;
      n_fail++;
      $display("FAIL idle timeout: busy=%b, expected 0", busy);
    end
    repeat (4) @(negedge clk);
  endtask

  // Line bit j (0..19) of a record: start, A5 LSB first, stop, start, payload, stop.
  function automatic logic frame_bit(input logic [7:0] pay, input int j);
    logic [7:0] s;
    s = 8'hA5;
    if (j == 0 || j == 10) return 1'b0;
    if (j == 9 || j >= 19) return 1'b1;
    if (j < 9) return s[j-1];
    return pay[j-11];
  endfunction

  // Bench UART receiver: samples mid-bit and queues each decoded byte.
  initial begin : monitor
    logic       prev;
    logic [7:0] b;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (mon_en && rst_n && prev && !uart_tx) begin
        repeat (DIV / 2) @(negedge clk);
        if (uart_tx !== 1'b0) frame_err++;
        for (int i = 0; i < 8; i++) begin
          repeat (DIV) @(negedge clk);
          b[i] = uart_tx;
        end
        repeat (DIV) @(negedge clk);
        if (uart_tx !== 1'b1) frame_err++;
        byte_q.push_back(b);
      end
      prev = uart_tx;
    end
  end

  initial begin : main
    int   bad;
    int   busy_bad;
    int   exp_drop;
    logic exp_tx;

    n_tests      = 0;
    n_fail       = 0;
    frame_err    = 0;
    mon_en       = 1'b1;
    rst_n        = 1'b0;
    offset_in    = '0;
    offset_valid = 1'b0;

    tbl[0] = '{5'b01111, 8'h0F};
    tbl[1] = '{5'b10000, 8'hF0};
    tbl[2] = '{5'b00000, 8'h00};

    // T1 reset
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("T1 tx in reset", uart_tx, 1'b1);
    check("T1 busy in reset", busy, 1'b0);
    check("T1 full in reset", fifo_full, 1'b0);
    check("T1 drops in reset", drop_count, 8'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("T1 tx after reset", uart_tx, 1'b1);
    check("T1 busy after reset", busy, 1'b0);
    check("T1 full after reset", fifo_full, 1'b0);
    check("T1 drops after reset", drop_count, 8'd0);
    bad = 0;
    repeat (10000) begin
      @(negedge clk);
      if (uart_tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    check("T1 quiet cycles", bad, 0);

    // T2 single -3; sample k is taken after edge N+k, N = push edge.
    @(posedge clk);
    #1;
    pulse(5'b11101);
    expect_rec(8'hFD);
    bad = 0;
    busy_bad = 0;
    for (int k = 0; k < REC + 4; k++) begin
      @(negedge clk);
      exp_tx = (k < 2) ? 1'b1 : frame_bit(8'hFD, (k - 2) / DIV);
      if (uart_tx !== exp_tx) bad++;
      if (k == 1) check("T2 line high at N+1", uart_tx, 1'b1);
      if (k == 2) check("T2 start bit at N+2", uart_tx, 1'b0);
      // FSM enters START_BIT at N+1, one edge before the line falls.
      if (busy !== (k <= REC)) busy_bad++;
      if (k == REC + 1) check("T2 busy fall", busy, 1'b0);
    end
    check("T2 waveform errors", bad, 0);
    check("T2 busy span errors", busy_bad, 0);
    drain(2000);
    wait_idle(2000);

    // T3 sign extension table, pushed on consecutive cycles
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      offset_in    = tbl[i].off;
      offset_valid = 1'b1;
      expect_rec(tbl[i].pay);
      @(posedge clk);
      #1;
    end
    offset_valid = 1'b0;
    drain(3 * (REC + 1) + 2000);
    wait_idle(2000);

    // T4 overflow: values 0..9 on ten consecutive cycles
    @(posedge clk);
    #1;
    for (int i = 0; i < 10; i++) begin
      offset_in    = 5'(i);
      offset_valid = 1'b1;
      if (i < 9) expect_rec(8'(i));
      @(negedge clk);
      if (i == 8) check("T4 full after 8 pushes", fifo_full, 1'b0);
      if (i == 9) check("T4 full after 9th push", fifo_full, 1'b1);
      @(posedge clk);
      #1;
    end
    offset_valid = 1'b0;
    @(negedge clk);
    check("T4 full after drop", fifo_full, 1'b1);
    check("T4 drop count", drop_count, 8'd1);
    // First record entered START_BIT at edge 2; next pop is edge 2+REC+1.
    repeat (REC - 8) @(posedge clk);
    @(negedge clk);
    check("T4 full before pop", fifo_full, 1'b1);
    @(posedge clk);
    @(negedge clk);
    check("T4 full after pop", fifo_full, 1'b0);
    drain(9 * (REC + 1) + 2000);
    wait_idle(2000);

    // T5 saturation: burst starts right after a pop
    mon_en = 1'b0;
    @(posedge clk);
    #1;
    pulse(5'd7);
    @(posedge clk);
    #1;
    offset_in    = 5'b01010;
    offset_valid = 1'b1;
    exp_drop = 1;
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (i >= 8 && exp_drop < 255) exp_drop++;
      if (drop_count !== 8'(exp_drop) || fifo_full !== (i >= 7)) bad++;
    end
    offset_valid = 1'b0;
    check("T5 drop tracking errors", bad, 0);
    check("T5 drop saturated", drop_count, 8'd255);

    // T6 reset during payload bit 3 of the record for 7 (bit 3 is 0)
    repeat (5994) @(posedge clk);
    #3;
    check("T6 payload bit3 on line", uart_tx, 1'b0);
    rst_n = 1'b0;
    #1;
    check("T6 tx forced high", uart_tx, 1'b1);
    check("T6 busy cleared", busy, 1'b0);
    check("T6 full cleared", fifo_full, 1'b0);
    check("T6 drops cleared", drop_count, 8'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    bad = 0;
    repeat (3000) begin
      @(negedge clk);
      if (uart_tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    check("T6 quiet after reset", bad, 0);
    byte_q.delete();
    mon_en = 1'b1;
    @(posedge clk);
    #1;
    pulse(5'b11111);
    expect_rec(8'hFF);
    drain(REC + 2000);
    wait_idle(2000);

    check("framing errors", frame_err, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
